vx_csr_access_unit: RTL
=======================

# vx_csr_access_unit

Issue-side counterpart of the per-core CSR storage block. Accepts decoded CSR instructions (CSRRW/CSRRS/CSRRC and immediate forms) from the dispatch stage and drives the storage block's combinational read port and registered write port as one atomic read-modify-write. Returns the old CSR value to writeback through a valid/ready response channel. The unit sustains one instruction per cycle when writeback is not back-pressuring.

## Interface
Parameters:
- TAG_WIDTH, 8, opaque instruction tag carried from request to response

Ports:
- clk  in  1  clock
- reset  in  1  reset; one clock domain, reset is synchronous and active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready at posedge
- req_wid  in  `NW_BITS  issuing warp
- req_tag  in  TAG_WIDTH  instruction tag
- req_addr  in  `CSR_ADDR_BITS  CSR address
- req_op  in  2  01=RW, 10=RS (set), 11=RC (clear); 00 illegal
- req_use_imm  in  1  source is req_imm (zero-extended) instead of req_rs1_data
- req_imm  in  5  immediate source
- req_rs1_data  in  32  register source (lane 0)
- req_rs1_zero  in  1  register-form source index is x0
- req_rd_en  in  1  destination register is written
- read_enable  out  1  storage read strobe
- read_addr  out  `CSR_ADDR_BITS  storage read address
- read_wid  out  `NW_BITS  storage read warp
- read_data  in  32  storage read data, combinational from read_addr/read_wid
- write_enable  out  1  storage write strobe, committed at posedge
- write_addr  out  `CSR_ADDR_BITS  storage write address
- write_wid  out  `NW_BITS  storage write warp
- write_data  out  32  new CSR value
- rsp_valid  out  1  response valid
- rsp_ready  in  1  writeback accepts response
- rsp_wid  out  `NW_BITS  warp
- rsp_tag  out  TAG_WIDTH  tag
- rsp_data  out  32  old CSR value
- rsp_rd_en  out  1  copy of req_rd_en
- busy  out  1  any instruction in flight

## Operation
- Two registers: S1 (accepted instruction) and RSP (response slot). No other state.
- S1 advances when s1_valid & (!rsp_valid | rsp_ready); advance loads RSP.
- req_ready = !s1_valid | advance.
- While s1_valid, read_addr/read_wid = S1 addr/wid; read_enable = advance.
- Source src = use_imm ? {27'b0, imm} : rs1_data.
- New value: RW → src; RS → read_data | src; RC → read_data & ~src.
- Write required: RW always; RS/RC only if source nonzero (imm form: imm != 0; reg form: !rs1_zero). RS/RC with x0 or imm 0 is a pure read.
- write_enable = advance & write required; write_addr/wid = S1 addr/wid, write_data = new value. Read and write share the same cycle, so the RMW is atomic: the response carries the pre-write value and the next instruction sees the post-write value with no hazard logic.
- Read/write strobes are never asserted on a stalled cycle; each instruction touches storage exactly once.
- RSP holds wid, tag, read_data sampled at advance, rd_en; cleared on rsp_valid&rsp_ready with no new advance.
- busy = s1_valid | rsp_valid.
- req_op == 00 is an assertion failure in simulation; hardware treats it as pure read.

## Timing
- Reset: s1_valid=0, rsp_valid=0; outputs read_enable=0, write_enable=0, rsp_valid=0, busy=0, req_ready=1; data/addr outputs 0.
- Latency: accept at edge N → storage access in cycle N+1 → rsp_valid high in cycle N+2 (if not stalled).
- Throughput: 1 per cycle with rsp_ready held high.
- Back-to-back same CSR/warp: second instruction reads the first's written value (write commits at the edge ending the first's access cycle).
- rsp_ready low: RSP holds all fields stable; S1 holds and performs no access; req_ready drops once S1 is occupied.
- Reset mid-operation: in-flight S1/RSP dropped, no write issued in the reset cycle.

## Configuration
- VX_CSR_RO_CHECK_EN defined: addresses with req_addr[11:10]==2'b11 (read-only space) never assert write_enable; response still returns read_data; simulation assertion fires if a write would have been required.
- Undefined: no address check; writes follow the write-required rule above.

## Test plan
- Reset, then RW addr 0x300 wid 1 src 0x1234 with storage holding 0xA → one write_enable of 0x1234 to (0x300,1); rsp_data=0xA two cycles after accept.
- RS reg form rs1_zero=1 on 0xC00 → write_enable never asserted, rsp_data = storage value.
- Back-to-back RS src 0x1 then RC src 0x3 on 0x001 (initial 0x4), rsp_ready=1 → writes 0x5 then 0x4, rsp_data 0x4 then 0x5, consecutive cycles.
- rsp_ready low for 5 cycles with 3 requests offered → exactly 2 accepted, no storage strobes during stall, responses in order with correct tags after release.
- Immediate RC imm=0 → no write; imm=5 on value 0xF → write 0xA.
- With VX_CSR_RO_CHECK_EN, RW to 0xF11 → no write, rsp_data = read_data; without the macro → write issued.

Source files
------------

// File: rtl/vx_csr_access_unit_if.sv
// Interfaces for vx_csr_access_unit.
//   vx_csr_req_if   : dispatch -> unit decoded CSR instruction (valid/ready)
//                     master = dispatch stage, slave = access unit
//   vx_csr_store_if : unit <-> per-core CSR storage block
//                     (combinational read port, registered write port)
//                     master = access unit, slave = storage block
//   vx_csr_rsp_if   : unit -> writeback old-value response (valid/ready)
//                     master = access unit, slave = writeback
// Width macros `NW_BITS (warp id) and `CSR_ADDR_BITS default to 2 and 12.
`timescale 1ns/1ps

`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif

interface vx_csr_req_if #(
    parameter int TAG_WIDTH = 8
);
    logic                      req_valid;
    logic                      req_ready;
    logic [`NW_BITS-1:0]       req_wid;
    logic [TAG_WIDTH-1:0]      req_tag;
    logic [`CSR_ADDR_BITS-1:0] req_addr;
    logic [1:0]                req_op;
    logic                      req_use_imm;
    logic [4:0]                req_imm;
    logic [31:0]               req_rs1_data;
    logic                      req_rs1_zero;
    logic                      req_rd_en;

    modport master (
        output req_valid, req_wid, req_tag, req_addr, req_op, req_use_imm,
               req_imm, req_rs1_data, req_rs1_zero, req_rd_en,
        input  req_ready
    );
    modport slave (
        input  req_valid, req_wid, req_tag, req_addr, req_op, req_use_imm,
               req_imm, req_rs1_data, req_rs1_zero, req_rd_en,
        output req_ready
    );
endinterface

interface vx_csr_store_if;
    logic                      read_enable;
    logic [`CSR_ADDR_BITS-1:0] read_addr;
    logic [`NW_BITS-1:0]       read_wid;
    logic [31:0]               read_data;
    logic                      write_enable;
    logic [`CSR_ADDR_BITS-1:0] write_addr;
    logic [`NW_BITS-1:0]       write_wid;
    logic [31:0]               write_data;

    modport master (
        output read_enable, read_addr, read_wid,
               write_enable, write_addr, write_wid, write_data,
        input  read_data
    );
    modport slave (
        input  read_enable, read_addr, read_wid,
               write_enable, write_addr, write_wid, write_data,
        output read_data
    );
endinterface

interface vx_csr_rsp_if #(
    parameter int TAG_WIDTH = 8
);
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [`NW_BITS-1:0]  rsp_wid;
    logic [TAG_WIDTH-1:0] rsp_tag;
    logic [31:0]          rsp_data;
    logic                 rsp_rd_en;

    modport master (
        output rsp_valid, rsp_wid, rsp_tag, rsp_data, rsp_rd_en,
        input  rsp_ready
    );
    modport slave (
        input  rsp_valid, rsp_wid, rsp_tag, rsp_data, rsp_rd_en,
        output rsp_ready
    );
endinterface

// File: rtl/vx_csr_access_unit.sv
// vx_csr_access_unit: issue-side CSR read-modify-write unit.
// Accepts CSRRW/CSRRS/CSRRC (register and immediate forms), performs the
// storage read and write in the same cycle (atomic RMW) and returns the old
// CSR value to writeback. One instruction per cycle without back-pressure.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   req        : vx_csr_req_if.slave   - decoded instruction from dispatch
//   store      : vx_csr_store_if.master - storage read/write ports
//   rsp        : vx_csr_rsp_if.master   - old value to writeback
//   busy       : an instruction is held in S1 or the response slot
// Optional feature: define VX_CSR_RO_CHECK_EN to suppress writes to the
// read-only CSR space (addr[11:10] == 2'b11).
`timescale 1ns/1ps

`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif

module vx_csr_access_unit #(
    parameter int TAG_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    vx_csr_req_if.slave    req,
    vx_csr_store_if.master store,
    vx_csr_rsp_if.master   rsp,
    output logic           busy
);

    typedef enum logic [1:0] {
        OP_ILLEGAL = 2'b00,
        OP_RW      = 2'b01,
        OP_RS      = 2'b10,
        OP_RC      = 2'b11
    } csr_op_e;

    // S1: accepted instruction
    logic                      s1_valid;
    logic [`NW_BITS-1:0]       s1_wid;
    logic [TAG_WIDTH-1:0]      s1_tag;
    logic [`CSR_ADDR_BITS-1:0] s1_addr;
    csr_op_e                   s1_op;
    logic                      s1_use_imm;
    logic [4:0]                s1_imm;
    logic [31:0]               s1_rs1_data;
    logic                      s1_rs1_zero;
    logic                      s1_rd_en;

    // RSP: response slot
    logic                      rsp_valid_q;
    logic [`NW_BITS-1:0]       rsp_wid_q;
    logic [TAG_WIDTH-1:0]      rsp_tag_q;
    logic [31:0]               rsp_data_q;
    logic                      rsp_rd_en_q;

    logic        advance;
    logic        accept;
    logic [31:0] src;
    logic        src_nonzero;
    logic [31:0] new_value;
    logic        write_req;
    logic        write_allowed;

    // reset gates the storage strobes so an in-flight instruction cannot
    // commit a write at the reset edge
    always_comb begin
        advance = s1_valid && (!rsp_valid_q || rsp.rsp_ready) && !reset;
        accept  = req.req_valid && req.req_ready;
    end

    always_comb begin
        src         = s1_use_imm ? {27'b0, s1_imm} : s1_rs1_data;
        src_nonzero = s1_use_imm ? (s1_imm != 5'd0) : !s1_rs1_zero;
        new_value   = store.read_data;
        write_req   = 1'b0;
        case (s1_op)
            OP_RW: begin
                new_value = src;
                write_req = 1'b1;
            end
            OP_RS: begin
                new_value = store.read_data | src;
                write_req = src_nonzero;
            end
            OP_RC: begin
                new_value = store.read_data & ~src;
                write_req = src_nonzero;
            end
            default: begin
                new_value = store.read_data;
                write_req = 1'b0;
            end
        endcase
    end

`ifdef VX_CSR_RO_CHECK_EN
    logic ro_space;
    always_comb begin
        ro_space      = (s1_addr[11:10] == 2'b11);
        write_allowed = write_req && !ro_space;
    end

    ro_write_attempt: assert property (
        @(posedge clk) disable iff (reset) !(advance && write_req && ro_space)
    ) else $error("write required to read-only CSR");
`else
    always_comb begin
        write_allowed = write_req;
    end
`endif

    always_comb begin
        req.req_ready      = !s1_valid || advance;

        store.read_enable  = advance;
        store.read_addr    = s1_addr;
        store.read_wid     = s1_wid;
        store.write_enable = advance && write_allowed;
        store.write_addr   = s1_addr;
        store.write_wid    = s1_wid;
        store.write_data   = s1_valid ? new_value : '0;

        rsp.rsp_valid      = rsp_valid_q;
        rsp.rsp_wid        = rsp_wid_q;
        rsp.rsp_tag        = rsp_tag_q;
        rsp.rsp_data       = rsp_data_q;
        rsp.rsp_rd_en      = rsp_rd_en_q;

        busy               = s1_valid || rsp_valid_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_wid      <= '0;
            s1_tag      <= '0;
            s1_addr     <= '0;
            s1_op       <= OP_ILLEGAL;
            s1_use_imm  <= 1'b0;
            s1_imm      <= '0;
            s1_rs1_data <= '0;
            s1_rs1_zero <= 1'b0;
            s1_rd_en    <= 1'b0;
        end else if (accept) begin
            s1_valid    <= 1'b1;
            s1_wid      <= req.req_wid;
            s1_tag      <= req.req_tag;
            s1_addr     <= req.req_addr;
            s1_op       <= csr_op_e'(req.req_op);
            s1_use_imm  <= req.req_use_imm;
            s1_imm      <= req.req_imm;
            s1_rs1_data <= req.req_rs1_data;
            s1_rs1_zero <= req.req_rs1_zero;
            s1_rd_en    <= req.req_rd_en;
        end else if (advance) begin
            s1_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_wid_q   <= '0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
            rsp_rd_en_q <= 1'b0;
        end else if (advance) begin
            rsp_valid_q <= 1'b1;
            rsp_wid_q   <= s1_wid;
            rsp_tag_q   <= s1_tag;
            rsp_data_q  <= store.read_data;
            rsp_rd_en_q <= s1_rd_en;
        end else if (rsp.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    illegal_op: assert property (
        @(posedge clk) disable iff (reset) accept |-> (req.req_op != 2'b00)
    ) else $error("illegal CSR op 00 accepted");

endmodule
